// File: rtl/cpu_trace_pkg.sv
// Shared types and helpers for the CPU trace monitor.
// Covers the monitor FSM encoding, the trace entry layout and the FIFO count width.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } mon_fsm_e;

    localparam int DEF_DATA_W = 32;

    // Field order matches the FIFO word layout {pc, ir, alu}.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] pc;
        logic [DEF_DATA_W-1:0] ir;
        logic [DEF_DATA_W-1:0] alu;
    } trace_entry_t;

    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cpu_trace_monitor_fifo.sv
// Synchronous show-ahead trace FIFO with a sticky drop-on-full flag.
// The read data is forced to zero while the FIFO is empty.
module trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rdata,
    output logic                        empty,
    output logic [count_w(DEPTH)-1:0]   count,
    output logic                        overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);
    localparam logic [CW-1:0] FULL_N = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == FULL_N);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_push) overflow <= 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Trace monitor for the multi-cycle MIPS core: detects commits on return to fetch,
// logs them into a trace FIFO, counts cycles/commits and halts on a branch-to-self spin.
module cpu_trace_monitor
    import cpu_trace_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int STATE_W     = 4,
    parameter int FETCH_STATE = 0,
    parameter int DEPTH       = 16,
    parameter int HALT_REPEAT = 4,
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clr,
    input  logic [STATE_W-1:0]          mon_state,
    input  logic [DATA_W-1:0]           mon_pc,
    input  logic [DATA_W-1:0]           mon_ir,
    input  logic [DATA_W-1:0]           mon_alu,
    input  logic                        rd_en,
    output logic                        rd_valid,
    output logic [DATA_W-1:0]           rd_pc,
    output logic [DATA_W-1:0]           rd_ir,
    output logic [DATA_W-1:0]           rd_alu,
    output logic [count_w(DEPTH)-1:0]   fifo_count,
    output logic                        overflow,
    output logic [CNT_W-1:0]            cycle_cnt,
    output logic [CNT_W-1:0]            instr_cnt,
    output logic                        halted,
    output logic [1:0]                  mon_fsm
);
    localparam int RL_W = $clog2(HALT_REPEAT + 1);
    localparam logic [STATE_W-1:0] FETCH  = STATE_W'(FETCH_STATE);
    localparam logic [RL_W-1:0]    HALT_N = RL_W'(HALT_REPEAT);

    mon_fsm_e           fsm;
    logic [STATE_W-1:0] prev_state;
    logic [RL_W-1:0]    run_len;
    logic [RL_W-1:0]    next_len;
    logic [DATA_W-1:0]  last_pc;
    logic               commit;
    logic               push;
    logic               fifo_empty;
    logic [3*DATA_W-1:0] head;

    assign commit = (mon_state == FETCH) && (prev_state != FETCH);
    assign push   = (fsm == RUN) && commit;
    // run_len == 0 marks "no previous commit", so the first commit never matches last_pc.
    assign next_len = ((run_len != '0) && (mon_pc == last_pc)) ? run_len + 1'b1 : RL_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= IDLE;
            prev_state <= FETCH;
            run_len    <= '0;
            last_pc    <= '0;
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
        end else begin
            prev_state <= mon_state;
            if (clr) begin
                fsm       <= IDLE;
                run_len   <= '0;
                last_pc   <= '0;
                cycle_cnt <= '0;
                instr_cnt <= '0;
            end else begin
                case (fsm)
                    IDLE: begin
                        if (en) fsm <= RUN;
                    end
                    RUN: begin
                        if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
                        if (push) begin
                            if (instr_cnt != '1) instr_cnt <= instr_cnt + 1'b1;
                            run_len <= next_len;
                            last_pc <= mon_pc;
                        end
                        if (push && (next_len == HALT_N)) fsm <= HALTED;
                        else if (!en)                      fsm <= IDLE;
                    end
                    HALTED: fsm <= HALTED;
                    default: fsm <= IDLE;
                endcase
            end
        end
    end

    trace_fifo #(
        .WIDTH (3*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .push     (push),
        .wdata    ({mon_pc, mon_ir, mon_alu}),
        .pop      (rd_en),
        .rdata    (head),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (overflow)
    );

    assign rd_valid = !fifo_empty;
    assign rd_pc    = head[3*DATA_W-1:2*DATA_W];
    assign rd_ir    = head[2*DATA_W-1:DATA_W];
    assign rd_alu   = head[DATA_W-1:0];
    assign halted   = (fsm == HALTED);
    assign mon_fsm  = fsm;

endmodule
